ddr3_stream_reader: RTL
=======================

Name: ddr3_stream_reader

Overview:
- Downstream consumer of the SD-card-to-DDR3 loader: once DDR3 is preloaded, it reads a requested range back through the MIG user (app) interface.
- Rebuilds each 128-bit burst into 64-bit words in the original SD byte order.
- Streams the words to a client (video/audio/sprite engine) over a valid/ready handshake.
- A credit-limited local FIFO absorbs MIG read latency without ever overflowing.

Parameters:
- FIFO_DEPTH, 16, number of 128-bit entries in the local buffer (power of 2, ≥4).
- ADDR_STEP, 8, MIG address increment per burst command (matches the loader's write stride).

Ports:
- clk  in  1  system/MIG user clock
- reset_n  in  1  asynchronous active-low reset
- init_done  in  1  high once DDR3 preload is complete; starts are ignored while low
- start  in  1  one-cycle pulse requesting a transfer
- start_addr  in  27  MIG address of the first burst
- burst_count  in  24  number of 128-bit bursts to read
- busy  out  1  high from accepted start until the last word leaves out_data
- done  out  1  one-cycle pulse when a transfer completes
- proto_err  out  1  sticky error: unexpected read beat or end marker
- ram_address  out  27  MIG app_addr
- ram_cmd  out  3  MIG app_cmd; always 3'b001 (read)
- ram_en  out  1  MIG app_en
- ram_rdy  in  1  MIG app_rdy
- ram_rd_data  in  64  MIG app_rd_data
- ram_rd_data_valid  in  1  MIG app_rd_data_valid
- ram_rd_data_end  in  1  MIG app_rd_data_end
- out_data  out  64  stream data
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; all counters, FIFO pointers and holding register cleared.
  - Outputs: busy=0, done=0, proto_err=0, ram_en=0, ram_address=0, out_valid=0, out_data=0. ram_cmd is constant 3'b001.
- Reset mid-transfer aborts immediately. No outstanding-response tracking survives reset; MIG shares the same reset.
- States:
  - IDLE: on start with init_done=1, latch start_addr into the address register and burst_count into the remaining counter, set busy, go to ISSUE. If burst_count=0, go to FINISH instead. start with init_done=0 is ignored.
  - ISSUE: assert ram_en when remaining>0 AND credits available.
    - Credits available means (fifo_count + outstanding) < FIFO_DEPTH.
    - A command is accepted on a cycle with ram_en=1 and ram_rdy=1. On acceptance: address += ADDR_STEP (mod 2^27), remaining -= 1, outstanding += 1.
    - ram_en held with a stable address until accepted; never dropped while ram_rdy=0 once asserted.
    - When remaining reaches 0, go to DRAIN.
  - DRAIN: wait until outstanding=0, FIFO empty, and the output serializer idle, then go to FINISH.
  - FINISH: pulse done for 1 cycle, clear busy, return to IDLE.
- start while busy=1 is ignored.
- Read return path, active in every state:
  - Beat A (ram_rd_data_valid=1, ram_rd_data_end=0) is stored into holding[127:64].
  - Beat B (valid=1, end=1) writes {holding[127:64], ram_rd_data} into the FIFO and decrements outstanding.
  - Errors set proto_err (sticky until reset) and drop the beat:
    - end=1 on a beat expected as A;
    - end=0 on a beat expected as B;
    - any valid beat while outstanding=0.
  - An error beat does not change outstanding.
  - The credit rule guarantees the FIFO is never full when beat B arrives.
- Output serializer: each 128-bit entry emits two words, low half first (bytes 0–7), then the high half (bytes 8–15).
  - This restores SD byte order: byte n of the block sits at bits [8n+7:8n] of the 128-bit entry.
  - out_data/out_valid are registered. They hold stable while out_valid=1 and out_ready=0.
  - The entry is popped after its high half transfers.
  - Sustained rate: 1 word/cycle when out_ready=1 and the FIFO is non-empty.
- A FIFO push and pop in the same cycle leave fifo_count unchanged.
- outstanding and fifo_count never exceed FIFO_DEPTH.
- Latency: first ram_en in the cycle after the accepted start; first out_valid at most 2 cycles after the first beat B.

Test Plan:
- init_done=1, start, start_addr=0, burst_count=4, MIG model with ram_rdy=1 and 10-cycle latency, out_ready=1 -> addresses 0,8,16,24 issued. 8 words out, word0 = bytes 0–7 of burst 0. done pulses once; busy falls the same cycle.
- start with burst_count=0 -> no ram_en; done pulse within 2 cycles; busy high for at most 2 cycles.
- out_ready=0 permanently, burst_count=40, FIFO_DEPTH=16 -> exactly 16 commands issued, then ram_en=0. Release out_ready -> remaining 24 issued; all 80 words arrive in order.
- ram_rdy toggled randomly, start_addr=27'h7FFFFF8, burst_count=2 -> addresses 7FFFFF8 then 0000000. ram_address stable while ram_en=1 and ram_rdy=0.
- Inject valid with end=1 as the first beat of a response -> proto_err=1 and stays 1. The beat is dropped; outstanding is unchanged.
- reset_n asserted mid-ISSUE with 3 outstanding -> all outputs return to reset values asynchronously. A fresh start after release behaves as in scenario 1.

Source files
------------

// File: rtl/ddr3_stream_reader_if.sv
// Bus bundle for ddr3_stream_reader: MIG app read port plus the 64-bit output stream.
// master = the reader, slave = the MIG/client side.
interface ddr3_stream_reader_if;
  logic [26:0] ram_address;
  logic [2:0]  ram_cmd;
  logic        ram_en;
  logic        ram_rdy;
  logic [63:0] ram_rd_data;
  logic        ram_rd_data_valid;
  logic        ram_rd_data_end;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output ram_address, ram_cmd, ram_en, out_data, out_valid,
    input  ram_rdy, ram_rd_data, ram_rd_data_valid, ram_rd_data_end, out_ready
  );

  modport slave (
    input  ram_address, ram_cmd, ram_en, out_data, out_valid,
    output ram_rdy, ram_rd_data, ram_rd_data_valid, ram_rd_data_end, out_ready
  );
endinterface

// File: rtl/ddr3_stream_reader.sv
// Reads a range of 128-bit bursts back from DDR3 via the MIG app port and streams them
// as 64-bit words (low half first) through a credit-limited local FIFO.
module ddr3_stream_reader #(
  parameter int unsigned FifoDepth = 16,
  parameter int unsigned AddrStep  = 8
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        init_done_i,
  input  logic        start_i,
  input  logic [26:0] start_addr_i,
  input  logic [23:0] burst_count_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        proto_err_o,
  ddr3_stream_reader_if.master bus
);
  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthW = (CntW + 1)'(FifoDepth);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFinish} state_e;

  state_e          state_q;
  logic [26:0]     addr_q;
  logic [23:0]     remaining_q;
  logic [CntW-1:0] outst_q, outst_d, count_q, count_d;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q, head_idx;
  logic [63:0]     hold_q;
  logic            expect_b_q;
  logic            ram_en_q, busy_q, done_q, err_q;
  logic [63:0]     out_data_q;
  logic            out_valid_q, hi_q;
  logic [127:0]    mem_q [FifoDepth];

  logic cmd_acc, beat_a, beat_b, beat_err, pop, advance, credit_ok, head_avail;

  always_comb begin
    cmd_acc  = ram_en_q & bus.ram_rdy;
    beat_a   = 1'b0;
    beat_b   = 1'b0;
    beat_err = 1'b0;
    if (bus.ram_rd_data_valid) begin
      if (outst_q == '0)                      beat_err = 1'b1;
      else if (expect_b_q == bus.ram_rd_data_end) begin
        beat_a = ~expect_b_q;
        beat_b = expect_b_q;
      end else                                beat_err = 1'b1;
    end
    pop     = out_valid_q & hi_q & bus.out_ready;
    advance = ~out_valid_q | bus.out_ready;
    outst_d = outst_q + CntW'(cmd_acc) - CntW'(beat_b);
    count_d = count_q + CntW'(beat_b) - CntW'(pop);
    // Credits cover FIFO occupancy plus every read still in flight.
    credit_ok  = ({1'b0, count_d} + {1'b0, outst_d}) < DepthW;
    head_idx   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    head_avail = pop ? (count_q > CntW'(1)) : (count_q != '0);
  end

  always_ff @(posedge clk_i) begin
    if (beat_b) mem_q[wr_ptr_q] <= {hold_q, bus.ram_rd_data};
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      outst_q     <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      hold_q      <= '0;
      expect_b_q  <= 1'b0;
      ram_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      hi_q        <= 1'b0;
    end else begin
      outst_q <= outst_d;
      count_q <= count_d;
      if (beat_err) err_q <= 1'b1;
      if (beat_a) begin
        hold_q     <= bus.ram_rd_data;
        expect_b_q <= 1'b1;
      end
      if (beat_b) begin
        expect_b_q <= 1'b0;
        wr_ptr_q   <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);

      // Serializer: low half, then high half, then the next entry's low half.
      if (advance) begin
        if (out_valid_q && !hi_q) begin
          out_data_q <= mem_q[rd_ptr_q][127:64];
          hi_q       <= 1'b1;
        end else if (head_avail) begin
          out_data_q  <= mem_q[head_idx][63:0];
          out_valid_q <= 1'b1;
          hi_q        <= 1'b0;
        end else begin
          out_valid_q <= 1'b0;
          hi_q        <= 1'b0;
        end
      end

      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start_i && init_done_i) begin
            addr_q      <= start_addr_i;
            remaining_q <= burst_count_i;
            busy_q      <= 1'b1;
            if (burst_count_i == '0) begin
              state_q <= StFinish;
            end else begin
              state_q  <= StIssue;
              ram_en_q <= credit_ok;
            end
          end
        end
        StIssue: begin
          if (cmd_acc) begin
            addr_q      <= addr_q + 27'(AddrStep);
            remaining_q <= remaining_q - 24'd1;
          end
          if (cmd_acc && remaining_q == 24'd1) begin
            state_q  <= StDrain;
            ram_en_q <= 1'b0;
          end else if (!(ram_en_q && !bus.ram_rdy)) begin
            ram_en_q <= credit_ok;
          end
        end
        StDrain: begin
          if (outst_q == '0 && count_q == '0 && !out_valid_q) state_q <= StFinish;
        end
        StFinish: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign proto_err_o     = err_q;
  assign bus.ram_address = addr_q;
  assign bus.ram_cmd     = 3'b001;
  assign bus.ram_en      = ram_en_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
endmodule
